// File: rtl/seat_status_reader.sv
`default_nettype none
// ============================================================================
// Module   : seat_status_reader
// Purpose  : Answers per-seat status queries by reading the seat table through
//            a 1-cycle synchronous read port. Defining SEAT_SCAN_EN adds a
//            background scanner that reports seats past their time limit.
// Revision : 1.0  initial release
// ============================================================================
module seat_status_reader #(
    parameter int NUM_SEATS = 32,
    parameter int SEAT_W    = 5,
    parameter int STU_W     = 25,
    parameter int TIME_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] now_time,
    input  logic [TIME_W-1:0] limit_time,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEAT_W-1:0] req_seat,
    output logic              mem_rd_en,
    output logic [SEAT_W-1:0] mem_rd_addr,
    input  logic              mem_rd_occ,
    input  logic [STU_W-1:0]  mem_rd_student,
    input  logic [TIME_W-1:0] mem_rd_start,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [SEAT_W-1:0] resp_seat,
    output logic [STU_W-1:0]  resp_student,
    output logic [1:0]        resp_state,
    output logic [TIME_W-1:0] resp_remaining,
    output logic              expire_valid,
    input  logic              expire_ready,
    output logic [SEAT_W-1:0] expire_seat,
    output logic              busy
);

`ifdef SEAT_SCAN_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD        = 3'd1,
        ST_WAIT      = 3'd2,
        ST_RESP      = 3'd3,
        ST_SCAN_RD   = 3'd4,
        ST_SCAN_WAIT = 3'd5,
        ST_EXP       = 3'd6
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;
`endif

    localparam logic [SEAT_W:0] c_num_seats = (SEAT_W+1)'(NUM_SEATS);
    localparam logic [1:0]      c_st_empty  = 2'b00;
    localparam logic [1:0]      c_st_seated = 2'b01;
    localparam logic [1:0]      c_st_over   = 2'b10;
    localparam logic [1:0]      c_st_inval  = 2'b11;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEAT_W-1:0]   r_seat;
    logic [SEAT_W-1:0]   r_resp_seat;
    logic [STU_W-1:0]    r_resp_student;
    logic [1:0]          r_resp_state;
    logic [TIME_W-1:0]   r_resp_remaining;
    logic [TIME_W-1:0]   w_elapsed;
    logic                w_over;
    logic [1:0]          w_class;
    logic                w_seat_ok;

    // Modular subtraction keeps elapsed correct across a timer wrap.
    assign w_elapsed = now_time - mem_rd_start;
    assign w_over    = mem_rd_occ && (w_elapsed >= limit_time);
    assign w_class   = !mem_rd_occ ? c_st_empty : (w_over ? c_st_over : c_st_seated);
    assign w_seat_ok = ({1'b0, req_seat} < c_num_seats);

`ifdef SEAT_SCAN_EN
    logic [SEAT_W-1:0] r_scan_ptr;
    logic              w_scan_adv;

    localparam logic [SEAT_W-1:0] c_last_seat = SEAT_W'(NUM_SEATS - 1);

    assign w_scan_adv = ((r_state == ST_SCAN_WAIT) && !w_over) ||
                        ((r_state == ST_EXP) && expire_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_ptr <= '0;
        end else if (w_scan_adv) begin
            r_scan_ptr <= (r_scan_ptr == c_last_seat) ? '0 : r_scan_ptr + 1'b1;
        end
    end

    assign expire_valid = (r_state == ST_EXP);
    assign expire_seat  = (r_state == ST_EXP) ? r_scan_ptr : '0;
`else
    logic w_unused;
    assign w_unused     = expire_ready;
    assign expire_valid = 1'b0;
    assign expire_seat  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seat           <= '0;
            r_resp_seat      <= '0;
            r_resp_student   <= '0;
            r_resp_state     <= '0;
            r_resp_remaining <= '0;
        end else begin
            if ((r_state == ST_IDLE) && req_valid) begin
                r_seat <= req_seat;
                if (!w_seat_ok) begin
                    r_resp_seat      <= req_seat;
                    r_resp_student   <= '0;
                    r_resp_state     <= c_st_inval;
                    r_resp_remaining <= '0;
                end
            end
            if (r_state == ST_WAIT) begin
                r_resp_seat      <= r_seat;
                r_resp_student   <= mem_rd_occ ? mem_rd_student : '0;
                r_resp_state     <= w_class;
                r_resp_remaining <= (w_class == c_st_seated) ? (limit_time - w_elapsed) : '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                // A pending query always wins over the scanner.
                if (req_valid) begin
                    w_state_nxt = w_seat_ok ? ST_RD : ST_RESP;
                end
`ifdef SEAT_SCAN_EN
                else begin
                    w_state_nxt = ST_SCAN_RD;
                end
`endif
            end
            ST_RD: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = r_seat;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef SEAT_SCAN_EN
            ST_SCAN_RD: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = r_scan_ptr;
                w_state_nxt = ST_SCAN_WAIT;
            end
            ST_SCAN_WAIT: begin
                w_state_nxt = w_over ? ST_EXP : ST_IDLE;
            end
            ST_EXP: begin
                if (expire_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign resp_valid     = (r_state == ST_RESP);
    assign resp_seat      = r_resp_seat;
    assign resp_student   = r_resp_student;
    assign resp_state     = r_resp_state;
    assign resp_remaining = r_resp_remaining;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
